// File: rtl/mem_read_arbiter_if.sv
// Bundles the two client read ports and the shared memory master port of mem_read_arbiter.
// The arbiter connects through the slave modport; the environment around it uses the master modport.
interface mem_read_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   a_address;
    logic                a_read;
    logic [DATA_W-1:0]   a_readdata;
    logic                a_waitrequest;
    logic [ADDR_W-1:0]   b_address;
    logic                b_read;
    logic [DATA_W-1:0]   b_readdata;
    logic                b_waitrequest;
    logic [ADDR_W-1:0]   master_address;
    logic                master_read;
    logic [DATA_W/8-1:0] master_byteenable;
    logic [DATA_W-1:0]   master_readdata;
    logic                master_waitrequest;
    logic                err_timeout;

    modport slave (
        input  a_address, a_read, b_address, b_read,
        input  master_readdata, master_waitrequest,
        output a_readdata, a_waitrequest, b_readdata, b_waitrequest,
        output master_address, master_read, master_byteenable, err_timeout
    );

    modport master (
        output a_address, a_read, b_address, b_read,
        output master_readdata, master_waitrequest,
        input  a_readdata, a_waitrequest, b_readdata, b_waitrequest,
        input  master_address, master_read, master_byteenable, err_timeout
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter serialising single-word reads from two Avalon-MM clients onto one read master.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_read_arbiter #(
    parameter int ADDR_W         = 20,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    mem_read_arbiter_if.slave bus,
    output logic [1:0]        o_dbg_state
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: a client holds read and address until it sees its waitrequest low for one
    // cycle (DONE); readdata is valid in that cycle. The master side holds address/read
    // until a cycle with master_waitrequest low, whose master_readdata is captured.
    state_t            r_state;
    logic              r_grant;       // 1 = client B
    logic              r_last_grant;  // 1 = client B
    logic [ADDR_W-1:0] r_m_addr;
    logic              r_m_read;
    logic [DATA_W-1:0] r_a_data;
    logic [DATA_W-1:0] r_b_data;
    logic              r_a_wait;
    logic              r_b_wait;

    logic w_pick_b;
    logic w_timeout;

    // On a tie the client that did not win last time is served.
    assign w_pick_b = bus.b_read & (~bus.a_read | ~r_last_grant);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state != S_BUSY) begin
                r_cnt <= '0;
            end else if (bus.master_waitrequest) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Fires on the stalled BUSY cycle that would be the TIMEOUT_CYCLES-th one.
    assign w_timeout       = (r_state == S_BUSY) && bus.master_waitrequest && (r_cnt == LIMIT);
    assign bus.err_timeout = r_err;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign w_timeout       = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_m_addr     <= '0;
            r_m_read     <= 1'b0;
            r_a_data     <= '0;
            r_b_data     <= '0;
            r_a_wait     <= 1'b1;
            r_b_wait     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.a_read || bus.b_read) begin
                        r_grant  <= w_pick_b;
                        r_m_addr <= w_pick_b ? bus.b_address : bus.a_address;
                        r_m_read <= 1'b1;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!bus.master_waitrequest) begin
                        if (r_grant) begin
                            r_b_data <= bus.master_readdata;
                            r_b_wait <= 1'b0;
                        end else begin
                            r_a_data <= bus.master_readdata;
                            r_a_wait <= 1'b0;
                        end
                        r_m_read <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (w_timeout) begin
                        if (r_grant) begin
                            r_b_data <= '1;
                            r_b_wait <= 1'b0;
                        end else begin
                            r_a_data <= '1;
                            r_a_wait <= 1'b0;
                        end
                        r_m_read <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_a_wait     <= 1'b1;
                    r_b_wait     <= 1'b1;
                    r_last_grant <= r_grant;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.master_address    = r_m_addr;
    assign bus.master_read       = r_m_read;
    assign bus.master_byteenable = {BE_W{1'b1}};
    assign bus.a_readdata        = r_a_data;
    assign bus.b_readdata        = r_b_data;
    assign bus.a_waitrequest     = r_a_wait;
    assign bus.b_waitrequest     = r_b_wait;
    assign o_dbg_state           = r_state;
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: vector table of one/two-client rounds plus corner sequences.
module tb_mem_read_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  mem_read_arbiter_if #(.ADDR_W(20), .DATA_W(32)) bus ();

  mem_read_arbiter #(.ADDR_W(20), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] exp_q[$];
  int          blen_q[$];
  int          a_pulses = 0;
  int          b_pulses = 0;

  int          slave_wait  = 0;
  bit          slave_stuck = 1'b0;
  logic [31:0] slave_data[8];
  int          slave_tx = 0;

  typedef struct {
    logic        a_req;
    logic [19:0] a_addr;
    logic        b_req;
    logic [19:0] b_addr;
    int          wait_c;
    logic [31:0] d0;
    logic [31:0] d1;
    int          n;
    logic [19:0] m0;
    logic [19:0] m1;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave memory model: answers each master read after slave_wait stalled cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.master_waitrequest = 1'b1;
    bus.master_readdata    = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (bus.master_read && !slave_stuck && (wcnt >= slave_wait)) begin
        bus.master_waitrequest = 1'b0;
        bus.master_readdata    = slave_data[slave_tx % 8];
        slave_tx++;
        wcnt = 0;
      end else begin
        bus.master_waitrequest = 1'b1;
        bus.master_readdata    = 32'hDEADBEEF;
        wcnt = bus.master_read ? wcnt + 1 : 0;
      end
    end
  end

  // Monitor / scoreboard: grant order, address stability, single-cycle waitrequest pulses.
  initial begin
    logic        prev_mr;
    logic [19:0] prev_ma;
    logic        prev_aw;
    logic        prev_bw;
    int          bcnt;
    prev_mr = 1'b0; prev_ma = '0; prev_aw = 1'b1; prev_bw = 1'b1; bcnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_mr = 1'b0; prev_aw = 1'b1; prev_bw = 1'b1; bcnt = 0;
      end else begin
        if (bus.master_read) begin
          if (prev_mr) begin
            check("master_addr_stable", bus.master_address, prev_ma);
          end else if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_master_read: got address 0x%0h, expected no read at %0t",
                     bus.master_address, $time);
          end else begin
            check("grant_order", bus.master_address, exp_q.pop_front());
          end
          bcnt++;
        end else if (prev_mr) begin
          blen_q.push_back(bcnt);
          bcnt = 0;
        end
        if (!bus.a_waitrequest) begin
          a_pulses++;
          check("a_wait_single_cycle", prev_aw, 1);
          check("b_wait_high_while_a_done", bus.b_waitrequest, 1);
        end
        if (!bus.b_waitrequest) begin
          b_pulses++;
          check("b_wait_single_cycle", prev_bw, 1);
        end
        prev_mr = bus.master_read;
        prev_ma = bus.master_address;
        prev_aw = bus.a_waitrequest;
        prev_bw = bus.b_waitrequest;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "global timeout");
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called right after a negedge. Returns the data seen with waitrequest low and the
  // number of negedges from request to that cycle.
  task automatic client_read(input bit is_b, input logic [19:0] addr, input bit scramble,
                             output logic [31:0] data, output int lat);
    bit got;
    got  = 1'b0;
    lat  = 0;
    data = '0;
    if (is_b) begin bus.b_read = 1'b1; bus.b_address = addr; end
    else      begin bus.a_read = 1'b1; bus.a_address = addr; end
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (scramble && lat == 1) begin
        if (is_b) bus.b_address = addr ^ 20'hFFFFF;
        else      bus.a_address = addr ^ 20'hFFFFF;
      end
      if (is_b ? !bus.b_waitrequest : !bus.a_waitrequest) begin
        got  = 1'b1;
        data = is_b ? bus.b_readdata : bus.a_readdata;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL client_read_timeout: client %0d address 0x%0h got no completion, expected one", is_b, addr);
    end
    @(negedge clk);
    if (is_b) bus.b_read = 1'b0;
    else      bus.a_read = 1'b0;
  endtask

  initial begin
    logic [31:0] da, db;
    int          la, lb, ap, bp;
    vec_t        v;

    bus.a_read = 1'b0; bus.a_address = '0;
    bus.b_read = 1'b0; bus.b_address = '0;

    vecs[0] = '{1'b1, 20'h00100, 1'b1, 20'h00200, 0, 32'h11110000, 32'h22220000, 2,
                20'h00100, 20'h00200, 32'h11110000, 32'h22220000};
    vecs[1] = '{1'b1, 20'h00010, 1'b0, 20'h00000, 0, 32'h12345678, 32'h00000000, 1,
                20'h00010, 20'h00000, 32'h12345678, 32'h22220000};
    vecs[2] = '{1'b1, 20'h00300, 1'b1, 20'h00400, 2, 32'h0000BBBB, 32'h0000AAAA, 2,
                20'h00400, 20'h00300, 32'h0000AAAA, 32'h0000BBBB};
    vecs[3] = '{1'b0, 20'h00000, 1'b1, 20'h0ABCD, 5, 32'hCAFEF00D, 32'h00000000, 1,
                20'h0ABCD, 20'h00000, 32'h0000AAAA, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 20'h00500, 1'b1, 20'h00600, 1, 32'h55555555, 32'h66666666, 2,
                20'h00500, 20'h00600, 32'h55555555, 32'h66666666};
    vecs[5] = '{1'b1, 20'hFFFFF, 1'b0, 20'h00000, 0, 32'hFFFFFFFE, 32'h00000000, 1,
                20'hFFFFF, 20'h00000, 32'hFFFFFFFE, 32'h66666666};

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_master_read", bus.master_read, 0);
    check("rst_master_address", bus.master_address, 0);
    check("rst_a_wait", bus.a_waitrequest, 1);
    check("rst_b_wait", bus.b_waitrequest, 1);
    check("rst_a_readdata", bus.a_readdata, 0);
    check("rst_b_readdata", bus.b_readdata, 0);
    check("rst_err_timeout", bus.err_timeout, 0);
    check("rst_byteenable", bus.master_byteenable, 4'hF);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      slave_wait    = v.wait_c;
      slave_data[0] = v.d0;
      slave_data[1] = v.d1;
      slave_tx      = 0;
      exp_q.push_back(v.m0);
      if (v.n == 2) exp_q.push_back(v.m1);
      da = '0; db = '0;
      fork
        begin if (v.a_req) client_read(1'b0, v.a_addr, 1'b0, da, la); end
        begin if (v.b_req) client_read(1'b1, v.b_addr, 1'b0, db, lb); end
      join
      if (v.a_req) check($sformatf("vec%0d_a_data_at_done", i), da, v.exp_a);
      if (v.b_req) check($sformatf("vec%0d_b_data_at_done", i), db, v.exp_b);
      check($sformatf("vec%0d_a_readdata_held", i), bus.a_readdata, v.exp_a);
      check($sformatf("vec%0d_b_readdata_held", i), bus.b_readdata, v.exp_b);
      check($sformatf("vec%0d_queue_drained", i), exp_q.size(), 0);
      check($sformatf("vec%0d_state_idle", i), dbg_state, 0);
      check($sformatf("vec%0d_byteenable", i), bus.master_byteenable, 4'hF);
    end

    // Single A read, zero-wait slave, address changed after grant
    do_reset();
    blen_q.delete();
    slave_wait = 0; slave_data[0] = 32'h12345678; slave_tx = 0;
    exp_q.push_back(20'h00010);
    bp = b_pulses;
    client_read(1'b0, 20'h00010, 1'b1, da, la);
    check("s1_latency", la, 2);
    check("s1_data", da, 32'h12345678);
    check("s1_busy_len", (blen_q.size() > 0) ? blen_q[0] : 0, 1);
    check("s1_a_wait_back_high", bus.a_waitrequest, 1);
    check("s1_b_no_pulse", b_pulses - bp, 0);

    // Four back-to-back reads from each client: strict alternation starting with A
    do_reset();
    slave_wait = 0; slave_tx = 0;
    for (int k = 0; k < 8; k++) slave_data[k] = 32'hD0000000 + k;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(20'h01000 + k);
      exp_q.push_back(20'h02000 + k);
    end
    fork
      begin
        logic [31:0] d2a;
        int          l2a;
        for (int k = 0; k < 4; k++) begin
          client_read(1'b0, 20'h01000 + k, 1'b0, d2a, l2a);
          check("s2_a_data", d2a, 32'hD0000000 + 2 * k);
        end
      end
      begin
        logic [31:0] d2b;
        int          l2b;
        for (int k = 0; k < 4; k++) begin
          client_read(1'b1, 20'h02000 + k, 1'b0, d2b, l2b);
          check("s2_b_data", d2b, 32'hD0000001 + 2 * k);
        end
      end
    join
    check("s2_queue_drained", exp_q.size(), 0);

    // B read with 5 stall cycles; A arrives mid-wait and is served next
    blen_q.delete();
    slave_wait = 5; slave_data[0] = 32'hCAFEF00D; slave_data[1] = 32'h77777777; slave_tx = 0;
    exp_q.push_back(20'h0ABCD);
    exp_q.push_back(20'h00077);
    fork
      begin client_read(1'b1, 20'h0ABCD, 1'b0, db, lb); end
      begin repeat (3) @(negedge clk); client_read(1'b0, 20'h00077, 1'b0, da, la); end
    join
    check("s3_b_data", db, 32'hCAFEF00D);
    check("s3_b_latency", lb, 7);
    check("s3_a_data", da, 32'h77777777);
    check("s3_busy_len", (blen_q.size() > 0) ? blen_q[0] : 0, 6);
    check("s3_queue_drained", exp_q.size(), 0);

    // A withdraws before being granted: no master transaction for it
    slave_wait = 3; slave_data[0] = 32'h22222222; slave_tx = 0;
    exp_q.push_back(20'h00222);
    ap = a_pulses;
    fork
      begin client_read(1'b1, 20'h00222, 1'b0, db, lb); end
      begin
        @(negedge clk);
        bus.a_address = 20'h00999; bus.a_read = 1'b1;
        @(negedge clk);
        bus.a_read = 1'b0;
      end
    join
    repeat (6) @(negedge clk);
    check("s4_withdraw_b_data", db, 32'h22222222);
    check("s4_withdraw_no_a_pulse", a_pulses - ap, 0);
    check("s4_withdraw_queue", exp_q.size(), 0);

    // A withdraws after grant: transaction still completes with a DONE pulse
    slave_wait = 2; slave_data[0] = 32'h33333333; slave_tx = 0;
    exp_q.push_back(20'h00333);
    ap = a_pulses;
    bus.a_address = 20'h00333; bus.a_read = 1'b1;
    @(negedge clk);
    bus.a_read = 1'b0;
    repeat (8) @(negedge clk);
    check("s4_late_withdraw_a_pulse", a_pulses - ap, 1);
    check("s4_late_withdraw_readdata", bus.a_readdata, 32'h33333333);
    check("s4_late_withdraw_queue", exp_q.size(), 0);

    // Reset while BUSY: outputs fall back without a clock edge, then A wins the tie
    slave_stuck = 1'b1;
    exp_q.push_back(20'h00444);
    bus.a_address = 20'h00444; bus.a_read = 1'b1;
    repeat (3) @(negedge clk);
    check("s5_busy_before_reset", dbg_state, 1);
    check("s5_read_before_reset", bus.master_read, 1);
    #1 reset = 1'b1;
    #1;
    check("s5_async_master_read", bus.master_read, 0);
    check("s5_async_master_address", bus.master_address, 0);
    check("s5_async_a_wait", bus.a_waitrequest, 1);
    check("s5_async_b_wait", bus.b_waitrequest, 1);
    check("s5_async_state", dbg_state, 0);
    bus.a_read = 1'b0;
    slave_stuck = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    slave_wait = 0; slave_data[0] = 32'h55550000; slave_data[1] = 32'h66660000; slave_tx = 0;
    exp_q.push_back(20'h00555);
    exp_q.push_back(20'h00666);
    fork
      begin client_read(1'b0, 20'h00555, 1'b0, da, la); end
      begin client_read(1'b1, 20'h00666, 1'b0, db, lb); end
    join
    check("s5_a_data", da, 32'h55550000);
    check("s5_b_data", db, 32'h66660000);
    check("s5_b_latency", lb, 5);
    check("s5_queue_drained", exp_q.size(), 0);

`ifdef ARB_TIMEOUT_EN
    // Completion on the limit cycle wins over the watchdog
    do_reset();
    blen_q.delete();
    slave_wait = 7; slave_data[0] = 32'h70707070; slave_tx = 0;
    exp_q.push_back(20'h00700);
    client_read(1'b0, 20'h00700, 1'b0, da, la);
    check("to_limit_data", da, 32'h70707070);
    check("to_limit_err", bus.err_timeout, 0);
    check("to_limit_latency", la, 9);
    check("to_limit_busy_len", (blen_q.size() > 0) ? blen_q[0] : 0, 8);

    // Stuck slave: watchdog completes with all ones and sets the sticky error
    blen_q.delete();
    slave_stuck = 1'b1; slave_tx = 0;
    exp_q.push_back(20'h00888);
    client_read(1'b0, 20'h00888, 1'b0, da, la);
    check("to_stuck_data", da, 32'hFFFFFFFF);
    check("to_stuck_err", bus.err_timeout, 1);
    check("to_stuck_latency", la, 9);
    check("to_stuck_busy_len", (blen_q.size() > 0) ? blen_q[0] : 0, 8);
    slave_stuck = 1'b0;
    slave_wait = 0; slave_data[0] = 32'h0B0B0B0B; slave_tx = 0;
    exp_q.push_back(20'h000B0);
    client_read(1'b1, 20'h000B0, 1'b0, db, lb);
    check("to_after_b_data", db, 32'h0B0B0B0B);
    check("to_err_sticky", bus.err_timeout, 1);
`else
    check("no_timeout_err_low", bus.err_timeout, 0);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Two-requester round-robin arbiter sharing one Avalon-MM read master port (external frame-buffer SRAM/SDRAM bridge) between two ISP pipeline clients, e.g. a line-fetch stage and a statistics/DMA stage.
- Each client sees an Avalon-MM slave read interface.
- The arbiter serialises single-word reads onto the shared master, holds address/read stable across master_waitrequest, and returns registered data to the granted client.

Parameters:
ADDR_W, 20, address width on client and master sides
DATA_W, 32, data width; byteenable width = DATA_W/8
TIMEOUT_CYCLES, 255, BUSY-state watchdog limit (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
a_address  in  ADDR_W  client A read address
a_read  in  1  client A read request, held until a_waitrequest low
a_readdata  out  DATA_W  client A read data, valid when a_waitrequest low
a_waitrequest  out  1  client A stall
b_address  in  ADDR_W  client B read address
b_read  in  1  client B read request
b_readdata  out  DATA_W  client B read data
b_waitrequest  out  1  client B stall
master_address  out  ADDR_W  shared master address (registered)
master_read  out  1  shared master read strobe (registered)
master_byteenable  out  DATA_W/8  constant all ones
master_readdata  in  DATA_W  slave read data, valid when master_waitrequest low with master_read high
master_waitrequest  in  1  slave stall
err_timeout  out  1  sticky watchdog error flag (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset values (async, immediate):
  - state=IDLE; master_read=0; master_address=0.
  - a_waitrequest=b_waitrequest=1; a_readdata=b_readdata=0.
  - last_grant=B, so A wins the first tie; err_timeout=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay.
  - Exactly one of a_read/b_read: grant it.
  - Both: grant the one not equal to last_grant.
  - On grant, register grant, master_address <= granted address, master_read <= 1, go BUSY.
- BUSY:
  - master_read=1 and master_address held constant.
  - When master_waitrequest=0: capture master_readdata into the granted client's readdata register, master_read <= 0, go DONE.
  - While master_waitrequest=1: stay.
- DONE:
  - Granted client's waitrequest driven 0 for exactly one cycle; its readdata valid that cycle.
  - last_grant <= grant; go IDLE.
- Non-granted client waitrequest stays 1 throughout.
- readdata registers hold their last value between transactions.
- Latency: a_read rising in IDLE with zero-wait slave -> completion (waitrequest low) in 3rd cycle. Minimum spacing between issued master reads is 3 cycles.
- Fairness: under continuous requests from both clients, grants strictly alternate; no starvation.
- Client read withdrawn before grant: ignored, no master transaction.
- Client read withdrawn after grant: master transaction completes normally; DONE still pulses that client's waitrequest low, and the data is discarded by the client.
- Address change by a client after grant: no effect; the latched address is used.
- Reset mid-BUSY: master_read drops asynchronously and the transaction is abandoned; the slave side must tolerate the abort.
- master_byteenable is always all ones, independent of state.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - 8-bit-minimum counter clears on BUSY entry and increments each BUSY cycle with master_waitrequest=1.
  - On reaching TIMEOUT_CYCLES: master_read <= 0, granted readdata <= all ones, go DONE, err_timeout <= 1.
  - err_timeout is sticky until reset.
  - A normal completion on the same cycle as the limit takes priority (real data, no error).
- Undefined: no counter; BUSY waits indefinitely; err_timeout constant 0.

Test Plan:
1. A only reads 0x00010, slave waitrequest 0 immediately, readdata 0x12345678 -> master_read high 1 cycle with address 0x00010; a_waitrequest low exactly 1 cycle, 3rd cycle after a_read, a_readdata=0x12345678; b_waitrequest stays 1.
2. After reset, A (0x00100) and B (0x00200) assert in the same cycle -> master_address sequence 0x00100 then 0x00200; A completes first, B 3 cycles later.
3. A and B each hold read for 4 back-to-back transactions -> grant order A,B,A,B,A,B,A,B; no client served twice consecutively while the other waits.
4. B read 0x0ABCD, slave waitrequest held 1 for 5 cycles, then readdata 0xCAFEF00D -> master_read/master_address stable 6 cycles; b_readdata=0xCAFEF00D on completion; A request arriving mid-wait is served next.
5. Reset asserted in BUSY -> master_read and master_address reach 0 and both waitrequests reach 1 without a clock edge; after release, simultaneous A/B requests -> A granted first.
6. With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave waitrequest stuck 1 -> after 8 BUSY cycles the client completes with readdata 0xFFFFFFFF and err_timeout=1; err_timeout remains 1 through later normal reads.
